// File: rtl/mult4u_redundant_scheduler.sv
// Round-robin sequencer sharing one external 4x4 multiplier; MULT4U_SCHED_DUAL_EN adds swapped re-execution with compare/retry.
// Latency accept->resp_valid: 2 cycles (4 with MULT4U_SCHED_DUAL_EN, +3 per retry); stalls in RESP while resp_ready is low.
module mult4u_redundant_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_RETRY = 2,
    parameter int IDW       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [3:0]           mult_a,
    output logic [3:0]           mult_b,
    input  logic [7:0]           mult_o,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [7:0]           resp_prod,
    output logic                 resp_err,
    output logic [7:0]           fault_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN1,
`ifdef MULT4U_SCHED_DUAL_EN
        ST_RUN2,
        ST_CHECK,
`endif
        ST_RESP
    } state_t;

    state_t         state_q;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [3:0]     mult_a_q;
    logic [3:0]     mult_b_q;
    logic           resp_valid_q;
    logic [7:0]     resp_prod_q;
    logic           resp_err_q;

`ifdef MULT4U_SCHED_DUAL_EN
    localparam logic [2:0] MAX_RETRY_L = 3'(MAX_RETRY);
    logic [7:0] p1_q;
    logic [7:0] p2_q;
    logic [2:0] retry_q;
    logic [7:0] fault_cnt_q;
`endif

    logic               win_found;
    logic [IDW-1:0]     win_id;
    logic [3:0]         win_a;
    logic [3:0]         win_b;
    logic [NUM_REQ-1:0] grant_oh;

    // Cyclic search for the first valid requester at or after rr_ptr_q.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        grant_oh  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_id    = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
        win_a = req_a[4*int'(win_id) +: 4];
        win_b = req_b[4*int'(win_id) +: 4];
        if (win_found) begin
            grant_oh[win_id] = 1'b1;
        end
    end

    assign req_ready  = (state_q == ST_IDLE && !rst) ? grant_oh : '0;
    assign mult_a     = mult_a_q;
    assign mult_b     = mult_b_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = id_q;
    assign resp_prod  = resp_prod_q;
    assign resp_err   = resp_err_q;
`ifdef MULT4U_SCHED_DUAL_EN
    assign fault_cnt  = fault_cnt_q;
`else
    assign fault_cnt  = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            id_q         <= '0;
            rr_ptr_q     <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_prod_q  <= '0;
            resp_err_q   <= 1'b0;
`ifdef MULT4U_SCHED_DUAL_EN
            p1_q         <= '0;
            p2_q         <= '0;
            retry_q      <= '0;
            fault_cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        id_q     <= win_id;
                        mult_a_q <= win_a;
                        mult_b_q <= win_b;
`ifdef MULT4U_SCHED_DUAL_EN
                        retry_q  <= '0;
`endif
                        state_q  <= ST_RUN1;
                    end
                end
`ifdef MULT4U_SCHED_DUAL_EN
                // The operand registers double as the job's a/b store: swap for RUN2, swap back on retry.
                ST_RUN1: begin
                    p1_q     <= mult_o;
                    mult_a_q <= mult_b_q;
                    mult_b_q <= mult_a_q;
                    state_q  <= ST_RUN2;
                end
                ST_RUN2: begin
                    p2_q    <= mult_o;
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (p1_q == p2_q) begin
                        resp_prod_q  <= p1_q;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        if (fault_cnt_q != 8'hFF) begin
                            fault_cnt_q <= fault_cnt_q + 8'd1;
                        end
                        if (retry_q < MAX_RETRY_L) begin
                            retry_q  <= retry_q + 3'd1;
                            mult_a_q <= mult_b_q;
                            mult_b_q <= mult_a_q;
                            state_q  <= ST_RUN1;
                        end else begin
                            resp_prod_q  <= p1_q;
                            resp_err_q   <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end
                    end
                end
`else
                ST_RUN1: begin
                    resp_prod_q  <= mult_o;
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
`endif
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        rr_ptr_q     <= (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + IDW'(1);
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult4u_redundant_scheduler.sv
// Directed bench for mult4u_redundant_scheduler with a golden multiplier that can inject faults on RUN2 cycles.
module tb_mult4u_redundant_scheduler;

`ifdef MULT4U_SCHED_DUAL_EN
    localparam int LAT   = 4;
    localparam int RST_K = 2;
`else
    localparam int LAT   = 2;
    localparam int RST_K = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic [3:0]  mult_a;
    logic [3:0]  mult_b;
    logic [7:0]  mult_o;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [7:0]  resp_prod;
    logic        resp_err;
    logic [7:0]  fault_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int since_acc = 100;
    int fault_mode = 0;
    logic fault_now;

    mult4u_redundant_scheduler #(.NUM_REQ(4), .MAX_RETRY(2), .IDW(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mult_a(mult_a), .mult_b(mult_b), .mult_o(mult_o),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_prod(resp_prod), .resp_err(resp_err), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_ready != 4'd0) since_acc <= 1;
        else                   since_acc <= since_acc + 1;
    end

    // Cycle T+k after acceptance; RUN2 falls on k = 2, 5, 8.
    always_comb begin
        fault_now = 1'b0;
        if (fault_mode == 1 && since_acc == 2) fault_now = 1'b1;
        if (fault_mode == 2 && since_acc % 3 == 2 && since_acc <= 8) fault_now = 1'b1;
    end

    assign mult_o = (8'(mult_a) * 8'(mult_b)) ^ {7'd0, fault_now};

    typedef struct {
        logic [3:0] mask;
        logic [3:0] a;
        logic [3:0] b;
        int         id;
        int         prod;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return -1;
    endfunction

    task automatic set_ops(input logic [3:0] a, input logic [3:0] b);
        for (int i = 0; i < 4; i++) begin
            req_a[4*i +: 4] = a;
            req_b[4*i +: 4] = b;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req_valid = 4'd0;
        resp_ready = 1'b0;
        fault_mode = 0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_grant;
        for (int k = 0; k < 20 && req_ready == 4'd0; k++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_resp;
        for (int k = 0; k < 40 && !resp_valid; k++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic run_job(input logic [3:0] mask, input logic [3:0] a, input logic [3:0] b,
                           input int id, input int prod, input int err, input int lat, input int fc);
        int t0;
        @(negedge clk);
        set_ops(a, b);
        req_valid = mask;
        #1;
        wait_grant();
        chk("grant", int'(req_ready), 1 << id);
        t0 = cyc;
        @(negedge clk); #1;
        req_valid = 4'd0;
        wait_resp();
        chk("latency", cyc - t0, lat);
        chk("resp_id", int'(resp_id), id);
        chk("resp_prod", int'(resp_prod), prod);
        chk("resp_err", int'(resp_err), err);
        chk("fault_cnt", int'(fault_cnt), fc);
        resp_ready = 1'b1;
        @(negedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_drop", int'(resp_valid), 0);
    endtask

    initial begin
        int gid[$];
        int rid[$];
        int rprod[$];
        int seen;

        vt[0] = '{4'b0100, 4'd13, 4'd11, 2, 143};
        vt[1] = '{4'b0011, 4'd0,  4'd9,  0, 0};
        vt[2] = '{4'b1001, 4'd15, 4'd15, 3, 225};
        vt[3] = '{4'b1010, 4'd1,  4'd1,  1, 1};
        vt[4] = '{4'b0001, 4'd8,  4'd2,  0, 16};
        vt[5] = '{4'b1111, 4'd7,  4'd9,  1, 63};
        vt[6] = '{4'b1100, 4'd15, 4'd1,  2, 15};
        vt[7] = '{4'b0110, 4'd3,  4'd5,  1, 15};
        vt[8] = '{4'b0010, 4'd6,  4'd5,  1, 30};

        // Reset state, with all requesters asserting to show req_ready is held off.
        rst = 1'b1;
        resp_ready = 1'b0;
        req_valid = 4'hF;
        set_ops(4'd3, 4'd3);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_mult_a", int'(mult_a), 0);
        chk("rst_mult_b", int'(mult_b), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_resp_id", int'(resp_id), 0);
        chk("rst_resp_prod", int'(resp_prod), 0);
        chk("rst_resp_err", int'(resp_err), 0);
        chk("rst_fault_cnt", int'(fault_cnt), 0);

        do_reset();
        foreach (vt[i]) run_job(vt[i].mask, vt[i].a, vt[i].b, vt[i].id, vt[i].prod, 0, LAT, 0);

        // All requesters valid continuously: grants rotate 0,1,2,3,0.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req_a[4*i +: 4] = 4'(i + 1);
            req_b[4*i +: 4] = 4'd15;
        end
        req_valid = 4'hF;
        resp_ready = 1'b1;
        for (int k = 0; k < 80 && rid.size() < 5; k++) begin
            #1;
            if (req_ready != 4'd0) gid.push_back(oh2i(req_ready));
            if (resp_valid) begin
                rid.push_back(int'(resp_id));
                rprod.push_back(int'(resp_prod));
            end
            @(negedge clk);
        end
        req_valid = 4'd0;
        resp_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            chk("rot_grant", (n < gid.size()) ? gid[n] : -1, n % 4);
            chk("rot_id", (n < rid.size()) ? rid[n] : -1, n % 4);
            chk("rot_prod", (n < rprod.size()) ? rprod[n] : -1, 15 * ((n % 4) + 1));
        end

        // Stall in RESP, then abort the next job with rst.
        do_reset();
        @(negedge clk);
        set_ops(4'd9, 4'd9);
        req_valid = 4'b0100;
        #1;
        wait_grant();
        chk("stall_grant", int'(req_ready), 4'b0100);
        @(negedge clk); #1;
        req_valid = 4'd0;
        wait_resp();
        for (int s = 0; s < 5; s++) begin
            chk("stall_valid", int'(resp_valid), 1);
            chk("stall_id", int'(resp_id), 2);
            chk("stall_prod", int'(resp_prod), 81);
            chk("stall_err", int'(resp_err), 0);
            @(negedge clk); #1;
        end
        resp_ready = 1'b1;
        @(negedge clk); #1;
        resp_ready = 1'b0;
        set_ops(4'd5, 4'd5);
        req_valid = 4'b0001;
        #1;
        chk("abort_grant", int'(req_ready), 4'b0001);
        @(negedge clk); #1;
        req_valid = 4'd0;
        for (int s = 1; s < RST_K; s++) begin
            @(negedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk); #1;
        chk("abort_req_ready", int'(req_ready), 0);
        chk("abort_mult_a", int'(mult_a), 0);
        chk("abort_mult_b", int'(mult_b), 0);
        chk("abort_resp_valid", int'(resp_valid), 0);
        chk("abort_resp_id", int'(resp_id), 0);
        chk("abort_resp_prod", int'(resp_prod), 0);
        chk("abort_resp_err", int'(resp_err), 0);
        chk("abort_fault_cnt", int'(fault_cnt), 0);
        rst = 1'b0;
        seen = 0;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk); #1;
            if (resp_valid) seen = 1;
        end
        chk("abort_no_resp", seen, 0);
        // rr_ptr back at 0 and state IDLE: requester 1 wins over 3 immediately.
        set_ops(4'd2, 4'd3);
        req_valid = 4'b1010;
        #1;
        chk("post_rst_grant", int'(req_ready), 4'b0010);
        @(negedge clk); #1;
        req_valid = 4'd0;
        wait_resp();
        chk("post_rst_prod", int'(resp_prod), 6);
        resp_ready = 1'b1;
        @(negedge clk); #1;
        resp_ready = 1'b0;

`ifdef MULT4U_SCHED_DUAL_EN
        // Single transient fault on the first RUN2: one retry.
        do_reset();
        fault_mode = 1;
        run_job(4'b0001, 4'd7, 4'd9, 0, 63, 0, 7, 1);
        // Persistent fault on every RUN2: retries exhausted.
        do_reset();
        fault_mode = 2;
        run_job(4'b0001, 4'd15, 4'd15, 0, 225, 1, 10, 3);
        fault_mode = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
